fmmu_sequencer: RTL

FMMU_SEQUENCER -- requirements
Module: fmmu_sequencer

---
 rtl/fmmu_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fmmu_sequencer.sv
// FMMU sequencer: scans a shadowed FMMU entry table against one datagram and issues mapped accesses.
// Optional FMMU_SEQ_MISS_CNT_EN adds a saturating count of datagrams that mapped no entry.
module fmmu_sequencer #(
  parameter int NUM_FMMU = 4
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_idx,
  input  logic        cfg_en,
  input  logic [15:0] cfg_phys_start,
  input  logic [31:0] cfg_log_start,
  input  logic [7:0]  cfg_log_len,
  input  logic        subdv,
  input  logic [31:0] sub_address,
  input  logic [7:0]  sub_len,
  output logic        busy,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_offset,
  output logic [7:0]  bus_len,
  output logic        done,
`ifdef FMMU_SEQ_MISS_CNT_EN
  output logic        hit,
  output logic [15:0] miss_cnt
`else
  output logic        hit
`endif
);

  localparam logic [3:0] LP_NUM  = 4'(NUM_FMMU);
  localparam logic [2:0] LP_LAST = 3'(NUM_FMMU - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ISSUE, S_DONE} state_t;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic        r_any;
  logic [31:0] r_addr;
  logic [7:0]  r_len;

  // Tables are sized for the full 3-bit index; entries >= NUM_FMMU are never written.
  logic        r_en    [8];
  logic [15:0] r_phys  [8];
  logic [31:0] r_log   [8];
  logic [7:0]  r_elen  [8];
  logic        r_sh_en   [8];
  logic [15:0] r_sh_phys [8];
  logic [31:0] r_sh_log  [8];
  logic [7:0]  r_sh_len  [8];

  logic [32:0] w_a, w_ae, w_l, w_le, w_s, w_e;
  logic        w_hit;
  logic        w_step;
  logic [15:0] w_baddr;
  logic [7:0]  w_boff, w_blen;

  always_comb begin
    w_a  = {1'b0, r_addr};
    w_ae = w_a + 33'(r_len);
    w_l  = {1'b0, r_sh_log[r_idx]};
    w_le = w_l + 33'(r_sh_len[r_idx]);
    w_s  = (w_a > w_l) ? w_a : w_l;
    w_e  = (w_ae < w_le) ? w_ae : w_le;
    w_hit = r_sh_en[r_idx] && (r_len != '0) && (r_sh_len[r_idx] != '0) && (w_s < w_e);
    // Differences are bounded by the 8-bit lengths, so truncated operands give exact results.
    w_baddr = r_sh_phys[r_idx] + w_s[15:0] - w_l[15:0];
    w_boff  = w_s[7:0] - w_a[7:0];
    w_blen  = w_e[7:0] - w_s[7:0];
    w_step  = ((r_state == S_CHECK) && !w_hit) || ((r_state == S_ISSUE) && bus_ack);
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_en   <= '{default: '0};
      r_phys <= '{default: '0};
      r_log  <= '{default: '0};
      r_elen <= '{default: '0};
    end else if (cfg_we && ({1'b0, cfg_idx} < LP_NUM)) begin
      r_en[cfg_idx]   <= cfg_en;
      r_phys[cfg_idx] <= cfg_phys_start;
      r_log[cfg_idx]  <= cfg_log_start;
      r_elen[cfg_idx] <= cfg_log_len;
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_any       <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_sh_en     <= '{default: '0};
      r_sh_phys   <= '{default: '0};
      r_sh_log    <= '{default: '0};
      r_sh_len    <= '{default: '0};
      busy        <= 1'b0;
      bus_req     <= 1'b0;
      bus_address <= '0;
      bus_offset  <= '0;
      bus_len     <= '0;
      done        <= 1'b0;
      hit         <= 1'b0;
`ifdef FMMU_SEQ_MISS_CNT_EN
      miss_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (subdv) begin
            r_addr    <= sub_address;
            r_len     <= sub_len;
            r_sh_en   <= r_en;
            r_sh_phys <= r_phys;
            r_sh_log  <= r_log;
            r_sh_len  <= r_elen;
            r_idx     <= '0;
            r_any     <= 1'b0;
            busy      <= 1'b1;
            r_state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_hit) begin
            bus_req     <= 1'b1;
            bus_address <= w_baddr;
            bus_offset  <= w_boff;
            bus_len     <= w_blen;
            r_any       <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus_ack) bus_req <= 1'b0;
        end
        S_DONE: begin
          done    <= 1'b0;
          hit     <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Shared advance for a CHECK miss and an acknowledged ISSUE.
      if (w_step) begin
        if (r_idx == LP_LAST) begin
          done    <= 1'b1;
          hit     <= r_any;
          r_state <= S_DONE;
`ifdef FMMU_SEQ_MISS_CNT_EN
          if (!r_any && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
`endif
        end else begin
          r_idx   <= r_idx + 3'd1;
          r_state <= S_CHECK;
        end
      end
    end
  end

endmodule
